// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared lane types and frame constants for the 4-lane TDM demux
package tdm_demux_pkg;
    localparam int LANES = 4;
    localparam logic [LANES-1:0] FULL_MASK = 4'b1111;
    typedef logic [1:0] lane_idx_t;
    typedef enum logic [0:0] {COLLECT = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial sample input and parallel frame output bundle
interface tdm_demux_if #(parameter int WIDTH = 1);
    import tdm_demux_pkg::*;
    logic in_valid;
    logic [WIDTH-1:0] in_data;
    lane_idx_t selector_bits;
    logic use_external_sel;
    logic in_ready;
    logic [LANES*WIDTH-1:0] out_lines;
    logic out_valid;
    logic out_ready;
    lane_idx_t cur_lane;
    logic dup_err;
    modport master(
        output in_valid, in_data, selector_bits, use_external_sel, out_ready,
        input in_ready, out_lines, out_valid, cur_lane, dup_err
    );
    modport slave(
        input in_valid, in_data, selector_bits, use_external_sel, out_ready,
        output in_ready, out_lines, out_valid, cur_lane, dup_err
    );
endinterface

// File: rtl/tdm_frame_reg.sv
// tdm_frame_reg: valid/ready holding register for completed frames
module tdm_frame_reg #(parameter int W = 4) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] frame,
    input  logic         out_ready,
    output logic [W-1:0] out_lines,
    output logic         out_valid
);
    always_ff @(posedge clk) begin
        if (reset) begin
            out_lines <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load) out_lines <= frame;
            out_valid <= load | (out_valid & ~out_ready);
        end
    end
endmodule

// File: rtl/tdm_demux_4.sv
// tdm_demux_4: steers serial samples into four lane slots and publishes whole frames
module tdm_demux_4 import tdm_demux_pkg::*; #(parameter int WIDTH = 1) (
    input logic clk,
    input logic reset,
    tdm_demux_if.slave bus
);
    state_t state;
    logic [LANES*WIDTH-1:0] shadow, shadow_nxt;
    logic [LANES-1:0] mask, mask_nxt;
    lane_idx_t cnt, lane;
    logic ext_q, ext, acc, free, complete, load, dup_q;
    // a new frame starts either from an empty mask or right after a held frame
    assign ext = (mask == '0 || state == FULL) ? bus.use_external_sel : ext_q;
    assign lane = ext ? bus.selector_bits : cnt;
    assign bus.cur_lane = lane;
    assign bus.in_ready = state == COLLECT;
    assign bus.dup_err = dup_q;
    assign acc = bus.in_valid & bus.in_ready;
    assign free = ~bus.out_valid | bus.out_ready;
    assign mask_nxt = mask | (acc ? 4'b0001 << lane : 4'b0000);
    assign complete = acc & (mask_nxt == FULL_MASK);
    assign load = free & (complete | state == FULL);
    always_comb begin
        shadow_nxt = shadow;
        if (acc) shadow_nxt[lane*WIDTH +: WIDTH] = bus.in_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
            shadow <= '0;
            mask <= '0;
            cnt <= '0;
            ext_q <= 1'b0;
            dup_q <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            dup_q <= acc & mask[lane];
            if (acc && mask == '0) ext_q <= bus.use_external_sel;
            if (load) begin
                mask <= '0;
                cnt <= '0;
                state <= COLLECT;
            end else begin
                mask <= mask_nxt;
                if (acc && !ext) cnt <= cnt + 2'd1;
                if (complete) state <= FULL;
            end
        end
    end
    tdm_frame_reg #(.W(LANES*WIDTH)) u_frame (
        .clk(clk),
        .reset(reset),
        .load(load),
        .frame(shadow_nxt),
        .out_ready(bus.out_ready),
        .out_lines(bus.out_lines),
        .out_valid(bus.out_valid)
    );
endmodule

// File: tb/tb_tdm_demux_4.sv
// tb_tdm_demux_4: vector table, corner sequences and random run against a frame-queue model
module tb_tdm_demux_4;
    logic clk = 1'b0;
    logic reset;
    int n_pass = 0;
    int n_total = 0;
    tdm_demux_if #(.WIDTH(4)) bus();
    tdm_demux_4 #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        bit iv; logic [3:0] d; logic [1:0] sel; bit ext; bit ordy;
        bit e_rdy; logic [1:0] e_cl; bit e_ov; logic [15:0] e_ol; bit e_dup;
    } vec_t;
    vec_t tbl[$];
    logic [3:0] m_slot[4];
    bit m_wr[4];
    bit m_mode;
    int m_cnt;
    logic [15:0] m_q[$];
    logic [15:0] m_out;
    bit m_dup;
    bit ext_r;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask
    function automatic bit m_any();
        return m_wr[0] | m_wr[1] | m_wr[2] | m_wr[3];
    endfunction
    function automatic bit m_rdy();
        return m_q.size() < 2;
    endfunction
    function automatic int m_cl();
        bit md = m_any() ? m_mode : bus.use_external_sel;
        return md ? int'(bus.selector_bits) : m_cnt;
    endfunction
    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_slot[k] = '0;
            m_wr[k] = 1'b0;
        end
        m_mode = 1'b0;
        m_cnt = 0;
        m_q.delete();
        m_out = '0;
        m_dup = 1'b0;
    endtask
    task automatic model_step();
        bit acc = bus.in_valid && m_rdy();
        bit pop = m_q.size() > 0 && bus.out_ready;
        bit md = m_any() ? m_mode : bus.use_external_sel;
        int ln = m_cl();
        m_dup = acc && m_wr[ln];
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            if (!m_any()) m_mode = bus.use_external_sel;
            m_slot[ln] = bus.in_data;
            m_wr[ln] = 1'b1;
            if (!md) m_cnt = (m_cnt + 1) % 4;
            if (m_wr[0] && m_wr[1] && m_wr[2] && m_wr[3]) begin
                m_q.push_back({m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
                for (int k = 0; k < 4; k++) m_wr[k] = 1'b0;
                m_cnt = 0;
            end
        end
        if (m_q.size() > 0) m_out = m_q[0];
    endtask
    task automatic apply(bit iv, logic [3:0] d, logic [1:0] s, bit e, bit r);
        bus.in_valid = iv;
        bus.in_data = d;
        bus.selector_bits = s;
        bus.use_external_sel = e;
        bus.out_ready = r;
        #1;
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        apply(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask
    task automatic step(vec_t v, string tag);
        apply(v.iv, v.d, v.sel, v.ext, v.ordy);
        chk({tag, "_in_ready"}, bus.in_ready, v.e_rdy);
        chk({tag, "_cur_lane"}, bus.cur_lane, v.e_cl);
        tick();
        chk({tag, "_out_valid"}, bus.out_valid, v.e_ov);
        chk({tag, "_out_lines"}, bus.out_lines, v.e_ol);
        chk({tag, "_dup_err"}, bus.dup_err, v.e_dup);
    endtask
    initial begin
        tbl.push_back('{1, 4'h1, 0, 0, 1, 1, 0, 0, 16'h0000, 0});
        tbl.push_back('{1, 4'h0, 0, 0, 1, 1, 1, 0, 16'h0000, 0});
        tbl.push_back('{1, 4'h1, 0, 0, 1, 1, 2, 0, 16'h0000, 0});
        tbl.push_back('{1, 4'h1, 0, 0, 1, 1, 3, 1, 16'h1101, 0});
        tbl.push_back('{0, 4'h0, 0, 0, 1, 1, 0, 0, 16'h1101, 0});
        tbl.push_back('{1, 4'hA, 3, 1, 1, 1, 3, 0, 16'h1101, 0});
        tbl.push_back('{1, 4'hB, 1, 1, 1, 1, 1, 0, 16'h1101, 0});
        tbl.push_back('{1, 4'hC, 0, 1, 1, 1, 0, 0, 16'h1101, 0});
        tbl.push_back('{1, 4'hD, 2, 1, 1, 1, 2, 1, 16'hADBC, 0});
        tbl.push_back('{0, 4'h0, 0, 0, 1, 1, 0, 0, 16'hADBC, 0});
        tbl.push_back('{1, 4'h5, 2, 1, 1, 1, 2, 0, 16'hADBC, 0});
        tbl.push_back('{1, 4'h9, 2, 1, 1, 1, 2, 0, 16'hADBC, 1});
        tbl.push_back('{1, 4'h1, 0, 1, 1, 1, 0, 0, 16'hADBC, 0});
        tbl.push_back('{1, 4'h2, 1, 1, 1, 1, 1, 0, 16'hADBC, 0});
        tbl.push_back('{1, 4'h3, 3, 1, 1, 1, 3, 1, 16'h3921, 0});
        tbl.push_back('{0, 4'h0, 0, 0, 1, 1, 0, 0, 16'h3921, 0});
        tbl.push_back('{1, 4'h4, 0, 0, 1, 1, 0, 0, 16'h3921, 0});
        tbl.push_back('{1, 4'h5, 0, 0, 1, 1, 1, 0, 16'h3921, 0});
        tbl.push_back('{1, 4'h6, 3, 1, 1, 1, 2, 0, 16'h3921, 0});
        tbl.push_back('{1, 4'h7, 3, 1, 1, 1, 3, 1, 16'h7654, 0});
        tbl.push_back('{1, 4'h8, 1, 1, 1, 1, 1, 0, 16'h7654, 0});
        tbl.push_back('{1, 4'h9, 0, 0, 1, 1, 0, 0, 16'h7654, 0});
        tbl.push_back('{1, 4'hA, 3, 0, 1, 1, 3, 0, 16'h7654, 0});
        tbl.push_back('{1, 4'hB, 2, 0, 1, 1, 2, 1, 16'hAB89, 0});
        tbl.push_back('{0, 4'h0, 0, 0, 1, 1, 0, 0, 16'hAB89, 0});
        do_reset();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_lines", bus.out_lines, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_cur_lane", bus.cur_lane, 0);
        chk("rst_dup_err", bus.dup_err, 0);
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 8; i++)
            step('{1, 4'(i + 1), 0, 0, 0, 1, 2'(i % 4), i >= 3, i >= 3 ? 16'h4321 : 16'hAB89, 0}, $sformatf("bp%0d", i));
        step('{1, 4'hF, 0, 0, 1, 0, 0, 1, 16'h8765, 0}, "bp_release");
        step('{0, 4'h0, 0, 0, 0, 1, 0, 1, 16'h8765, 0}, "bp_resume");
        for (int i = 0; i < 4; i++)
            step('{1, 4'(i + 1), 0, 0, 0, 1, 2'(i), 1, 16'h8765, 0}, $sformatf("fill%0d", i));
        apply(0, 0, 0, 0, 0);
        chk("full_in_ready", bus.in_ready, 0);
        do_reset();
        chk("rfull_out_valid", bus.out_valid, 0);
        chk("rfull_in_ready", bus.in_ready, 1);
        chk("rfull_cur_lane", bus.cur_lane, 0);
        chk("rfull_out_lines", bus.out_lines, 0);
        for (int i = 0; i < 4; i++)
            step('{1, 4'(i + 1), 0, 0, 1, 1, 2'(i), i == 3, i == 3 ? 16'h4321 : 16'h0000, 0}, $sformatf("post%0d", i));
        do_reset();
        ext_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            if ($urandom_range(7) == 0) ext_r = ~ext_r;
            apply($urandom_range(3) != 0, 4'($urandom), 2'($urandom), ext_r, $urandom_range(2) != 0);
            chk("rnd_in_ready", bus.in_ready, m_rdy());
            chk("rnd_cur_lane", bus.cur_lane, m_cl());
            tick();
            chk("rnd_out_valid", bus.out_valid, m_q.size() > 0);
            chk("rnd_out_lines", bus.out_lines, m_out);
            chk("rnd_dup_err", bus.dup_err, m_dup);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tdm_demux_4.md
Name: tdm_demux_4

Overview:
- Time-division 1-to-4 demultiplexer. It is the distribution end of the 4-lane select path.
- It accepts samples one at a time on a single input with a 2-bit lane selector, or with an internally sequenced lane index.
- It steers each sample into one of four lane slots and publishes a complete 4-lane frame through a valid/ready output register.
- It sits upstream of the 4:1 selection logic, rebuilding parallel input_lines from a serialized stream.

Parameters:
- WIDTH, 1, bits per lane sample.
- LANES, 4, number of lanes. Fixed at 4; the selector is 2 bits wide.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  sample present on in_data.
- in_data  input  WIDTH  sample value.
- selector_bits  input  2  destination lane; used in external mode only.
- use_external_sel  input  1  1 = lane taken from selector_bits; 0 = internal lane counter.
- in_ready  output  1  block accepts a sample this cycle.
- out_lines  output  4*WIDTH  frame; lane k occupies [k*WIDTH +: WIDTH].
- out_valid  output  1  out_lines holds an unconsumed frame.
- out_ready  input  1  consumer takes the frame.
- cur_lane  output  2  lane the next accepted sample will fill.
- dup_err  output  1  one-cycle pulse when a lane is rewritten within a frame.

Behaviour:
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Reset values (synchronous, reset dominates all other events):
  - State = COLLECT; shadow register = 0; written mask = 4'b0000; lane counter = 0.
  - out_lines = 0; out_valid = 0; dup_err = 0; latched mode = 0.
- Mode latching:
  - use_external_sel is latched only on an accept while the mask is 4'b0000 (frame start).
  - Changes mid-frame are ignored until the next frame.
- Lane index:
  - External mode: lane = selector_bits.
  - Auto mode: lane = counter. Counter increments on each accept and wraps 3 -> 0.
  - cur_lane shows the counter in auto mode and selector_bits in external mode.
- On accept:
  - Shadow[lane] <= in_data; mask[lane] <= 1.
  - If mask[lane] was already 1: overwrite the slot and pulse dup_err the next cycle. The frame is not aborted.
- Frame complete: the accept that makes the mask 4'b1111 (the updated mask, not the old one).
- State COLLECT, in_ready = 1:
  - On frame complete, if the output is free (out_valid = 0, or a pop occurs in the same cycle):
    - out_lines <= shadow including the current sample; out_valid <= 1.
    - Mask <= 0; counter <= 0; stay in COLLECT.
  - Otherwise go to FULL.
- State FULL, in_ready = 0:
  - Shadow is held.
  - When out_valid = 0 or a pop occurs: transfer shadow to out_lines, out_valid <= 1, mask <= 0, counter <= 0, go to COLLECT.
- Output register:
  - out_valid clears on a pop with no simultaneous transfer.
  - A pop and a transfer in the same cycle leave out_valid = 1 with the new frame.
  - out_lines is stable while out_valid = 1 and out_ready = 0.
- Latency:
  - Frame-completing sample accepted at edge N -> out_valid = 1 after edge N, with an unblocked output.
  - Throughput: one sample per cycle, one frame per 4 cycles with out_ready held at 1.
- Boundaries:
  - in_valid = 0 mid-frame: partial mask retained indefinitely.
  - Reset mid-frame or mid-FULL: partial frame and held frame are discarded.
  - out_ready with out_valid = 0 has no effect.

Decomposition:
- Package tdm_demux_pkg holds:
  - Typedef lane_idx_t (logic [1:0]).
  - Enum state_t {COLLECT, FULL}.
  - Constant LANES = 4.
  - Constant FULL_MASK = 4'b1111.
- One natural sub-module: tdm_frame_reg, the output valid/ready holding register with load/pop logic.
- The lane decode and mask logic stay in the top module.

Test Plan:
- Auto mode, WIDTH=1, out_ready=1; samples 1,0,1,1 on consecutive cycles -> out_lines = 4'b1101 (lane0 = LSB) and out_valid = 1 for one cycle after the 4th accept; cur_lane sequence 0,1,2,3,0.
- External mode, WIDTH=4; selectors 3,1,0,2 with data A,B,C,D -> out_lines = {B... lane order} = 16'hB A? Lanes are placed by index: lane3 = A, lane1 = B, lane0 = C, lane2 = D, giving out_lines = 16'hADBC. No dup_err.
- Backpressure, out_ready = 0; stream 8 samples in auto mode -> first frame held with out_lines stable; in_ready drops after the 8th accept (FULL). Raising out_ready for 1 cycle -> second frame loaded, out_valid stays 1, in_ready returns to 1.
- External mode; write lane 2 twice (5 then 9), then lanes 0, 1, 3 -> dup_err pulses once; lane2 = 9 in the output frame; frame completes on the 5th accept.
- Mode toggle: switch use_external_sel after 2 auto-mode accepts -> ignored, and the frame completes in auto order; the next frame uses external mode.
- Reset asserted in FULL with out_valid = 1 -> next cycle out_valid = 0, in_ready = 1, cur_lane = 0, out_lines = 0; a new 4-sample frame completes normally.
